// File: rtl/ram_arbiter_pkg.sv
// Shared types and encodings for the two-master data RAM arbiter.
// Bus control encodings, FSM state encodings and the arbiter grant record.
package ram_arbiter_pkg;

  localparam logic IO_CTRL_READ  = 1'b0;
  localparam logic IO_CTRL_WRITE = 1'b1;

  typedef enum logic [1:0] {
    RARB_IDLE   = 2'd0,
    RARB_ACCESS = 2'd1,
    RARB_DONE   = 2'd2
  } rarb_state_e;

  typedef struct packed {
    logic valid;   // at least one master requesting
    logic winner;  // 0 = master 0, 1 = master 1
  } arb_grant_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way grant: a qualified lock holds the last owner, otherwise
// a single requester wins and ties go to master 0 (fixed) or the pointer (round-robin).
module rr_arb2
  import ram_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0]  req_i,
  input  logic        last_owner_i,
  input  logic        prefer_i,
  input  logic        lock_hold_i,
  output arb_grant_t  grant_o
);

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    grant_o       = '0;
    grant_o.valid = |req_i;
    if (lock_hold_i) begin
      grant_o.winner = last_owner_i;
    end else if (req_i == 2'b11) begin
      grant_o.winner = (FIXED_PRIO != 0) ? 1'b0 : prefer_i;
    end else begin
      grant_o.winner = req_i[1];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between the CPU (master 0) and DMA (master 1).
// Request to ram_en is one cycle, ram_en to ack is one cycle; the RAM read latency lands in DONE.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int CPU_WIDTH  = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_LOCK   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic                  m0_lock,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [CPU_WIDTH-1:0]  m0_wdata,
  output logic                  m0_ack,
  output logic [CPU_WIDTH-1:0]  m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic                  m1_lock,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [CPU_WIDTH-1:0]  m1_wdata,
  output logic                  m1_ack,
  output logic [CPU_WIDTH-1:0]  m1_rdata,
  output logic                  ram_en,
  output logic                  ram_ctrl,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [CPU_WIDTH-1:0]  ram_wdata,
  input  logic [CPU_WIDTH-1:0]  ram_rdata,
  output logic                  busy,
  output logic                  owner
);

  localparam int              CNT_W    = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

  rarb_state_e           state_q;
  logic                  ram_en_q, ram_ctrl_q, owner_q, prefer_q;
  logic                  m0_ack_q, m1_ack_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [CPU_WIDTH-1:0]  ram_wdata_q, m0_rdata_q, m1_rdata_q;
  logic [CNT_W-1:0]      lock_cnt_q, lock_cnt_d;

  logic                  owner_req, owner_lock, other_req, lock_want, lock_hold;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [CPU_WIDTH-1:0]  win_wdata;
  arb_grant_t            grant;

  assign owner_req  = owner_q ? m1_req  : m0_req;
  assign owner_lock = owner_q ? m1_lock : m0_lock;
  assign other_req  = owner_q ? m0_req  : m1_req;
  assign lock_want  = owner_req & owner_lock;
  assign lock_hold  = lock_want & (lock_cnt_q < LOCK_MAX);

  rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .req_i       ({m1_req, m0_req}),
    .last_owner_i(owner_q),
    .prefer_i    (prefer_q),
    .lock_hold_i (lock_hold),
    .grant_o     (grant)
  );

  always_comb begin
    win_we    = m0_we;
    win_addr  = m0_addr;
    win_wdata = m0_wdata;
    if (grant.winner) begin
      win_we    = m1_we;
      win_addr  = m1_addr;
      win_wdata = m1_wdata;
    end
    // A lock against an idle rival keeps winning with the count pinned at its limit.
    lock_cnt_d = '0;
    if (lock_hold) begin
      lock_cnt_d = lock_cnt_q + CNT_W'(1);
    end else if (lock_want && !other_req) begin
      lock_cnt_d = lock_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RARB_IDLE;
      ram_en_q    <= 1'b0;
      ram_ctrl_q  <= IO_CTRL_READ;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      owner_q     <= 1'b0;
      prefer_q    <= 1'b0;
      lock_cnt_q  <= '0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every branch sees last cycle's owner/ctrl.
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      case (state_q)
        RARB_ACCESS: begin
          ram_en_q <= 1'b0;
          if (owner_q) m1_ack_q <= 1'b1;
          else         m0_ack_q <= 1'b1;
          state_q  <= RARB_DONE;
        end
        RARB_IDLE, RARB_DONE: begin
          if (state_q == RARB_DONE && ram_ctrl_q == IO_CTRL_READ) begin
            if (owner_q) m1_rdata_q <= ram_rdata;
            else         m0_rdata_q <= ram_rdata;
          end
          if (grant.valid) begin
            state_q     <= RARB_ACCESS;
            ram_en_q    <= 1'b1;
            ram_ctrl_q  <= win_we ? IO_CTRL_WRITE : IO_CTRL_READ;
            ram_addr_q  <= win_addr;
            ram_wdata_q <= win_wdata;
            owner_q     <= grant.winner;
            prefer_q    <= ~grant.winner;
            lock_cnt_q  <= lock_cnt_d;
          end else begin
            state_q <= RARB_IDLE;
          end
        end
        default: state_q <= RARB_IDLE;
      endcase
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_ctrl  = ram_ctrl_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign owner     = owner_q;
  assign busy      = (state_q != RARB_IDLE);

  // Read data is live only for the owner in its ack cycle; otherwise the last value holds.
  assign m0_rdata = (state_q == RARB_DONE && !owner_q && ram_ctrl_q == IO_CTRL_READ)
                    ? ram_rdata : m0_rdata_q;
  assign m1_rdata = (state_q == RARB_DONE &&  owner_q && ram_ctrl_q == IO_CTRL_READ)
                    ? ram_rdata : m1_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: round-robin and fixed-priority instances share master inputs,
// each backed by a behavioural RAM; acks are scored against an expected-transaction queue.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int DW = 16;
  localparam int AW = 10;

  typedef struct {
    logic          master;
    logic          is_read;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;

  logic          a_m0_ack, a_m1_ack, a_ram_en, a_ram_ctrl, a_busy, a_owner;
  logic [DW-1:0] a_m0_rdata, a_m1_rdata, a_ram_wdata, a_ram_rdata;
  logic [AW-1:0] a_ram_addr;
  logic          b_m0_ack, b_m1_ack, b_ram_en, b_ram_ctrl, b_busy, b_owner;
  logic [DW-1:0] b_m0_rdata, b_m1_rdata, b_ram_wdata, b_ram_rdata;
  logic [AW-1:0] b_ram_addr;

  ram_arbiter #(.CPU_WIDTH(DW), .ADDR_WIDTH(AW), .FIXED_PRIO(0), .MAX_LOCK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata),
    .ram_en(a_ram_en), .ram_ctrl(a_ram_ctrl), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata),
    .ram_rdata(a_ram_rdata), .busy(a_busy), .owner(a_owner)
  );

  ram_arbiter #(.CPU_WIDTH(DW), .ADDR_WIDTH(AW), .FIXED_PRIO(1), .MAX_LOCK(4)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .ram_en(b_ram_en), .ram_ctrl(b_ram_ctrl), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
    .ram_rdata(b_ram_rdata), .busy(b_busy), .owner(b_owner)
  );

  logic [DW-1:0] a_mem [0:(1<<AW)-1];
  logic [DW-1:0] b_mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (a_ram_en) begin
      if (a_ram_ctrl == IO_CTRL_WRITE) a_mem[a_ram_addr] <= a_ram_wdata;
      a_ram_rdata <= a_mem[a_ram_addr];
    end
    if (b_ram_en) begin
      if (b_ram_ctrl == IO_CTRL_WRITE) b_mem[b_ram_addr] <= b_ram_wdata;
      b_ram_rdata <= b_mem[b_ram_addr];
    end
  end

  logic          mon_fp;
  logic          s_m0_ack, s_m1_ack;
  logic [DW-1:0] s_m0_rdata, s_m1_rdata;
  assign s_m0_ack   = mon_fp ? b_m0_ack   : a_m0_ack;
  assign s_m1_ack   = mon_fp ? b_m1_ack   : a_m1_ack;
  assign s_m0_rdata = mon_fp ? b_m0_rdata : a_m0_rdata;
  assign s_m1_rdata = mon_fp ? b_m1_rdata : a_m1_rdata;

  int            checks = 0;
  int            errors = 0;
  exp_t          sb_q[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic m, input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data);
    exp_t e;
    e.master  = m;
    e.is_read = !we;
    if (we) ref_mem[addr] = data;
    e.data = ref_mem[addr];
    sb_q.push_back(e);
  endtask

  task automatic set_m(input logic m, input logic req, input logic we, input logic lock,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (m) begin
      m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdata = data;
    end else begin
      m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wdata = data;
    end
  endtask

  // One clock; every ack seen is matched against the head of the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (s_m0_ack || s_m1_ack) begin
      check("ack_exclusive", {31'd0, s_m0_ack & s_m1_ack}, 32'd0);
      check("ack_expected", {31'd0, sb_q.size() > 0}, 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("ack_master", {31'd0, s_m1_ack}, {31'd0, e.master});
        if (e.is_read)
          check("rdata", {16'd0, e.master ? s_m1_rdata : s_m0_rdata}, {16'd0, e.data});
      end
    end
  endtask

  task automatic do_single(input logic m, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data);
    int   n;
    logic got;
    n   = 0;
    got = 1'b0;
    push(m, we, addr, data);
    set_m(m, 1'b1, we, 1'b0, addr, data);
    while (!got && n < 8) begin
      tick();
      n++;
      got = m ? s_m1_ack : s_m0_ack;
    end
    check("single_latency", n, 2);
    set_m(m, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    set_m(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_m(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int acks;
    mon_fp = 1'b0;
    rst_n  = 1'b0;
    set_m(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_m(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);

    // Reset state of both instances
    check("rst_ram_en", {31'd0, a_ram_en}, 32'd0);
    check("rst_ram_ctrl", {31'd0, a_ram_ctrl}, {31'd0, IO_CTRL_READ});
    check("rst_ram_addr", {22'd0, a_ram_addr}, 32'd0);
    check("rst_ram_wdata", {16'd0, a_ram_wdata}, 32'd0);
    check("rst_acks", {30'd0, a_m1_ack, a_m0_ack}, 32'd0);
    check("rst_owner", {31'd0, a_owner}, 32'd0);
    check("rst_busy", {31'd0, a_busy}, 32'd0);
    check("rst_fp_busy_en", {30'd0, b_busy, b_ram_en}, 32'd0);
    rst_n = 1'b1;

    // Single write then read on master 0; address change during ACCESS is ignored
    push(1'b0, 1'b1, 10'h012, 16'hBEEF);
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 10'h012, 16'hBEEF);
    tick();
    check("wr_ram_en", {31'd0, a_ram_en}, 32'd1);
    check("wr_ram_ctrl", {31'd0, a_ram_ctrl}, {31'd0, IO_CTRL_WRITE});
    check("wr_ram_addr", {22'd0, a_ram_addr}, 32'h012);
    check("wr_ram_wdata", {16'd0, a_ram_wdata}, 32'hBEEF);
    check("wr_no_early_ack", {31'd0, a_m0_ack}, 32'd0);
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 10'h3FF, 16'h0000);
    tick();
    check("wr_ack", {31'd0, a_m0_ack}, 32'd1);
    check("wr_en_one_cycle", {31'd0, a_ram_en}, 32'd0);
    check("wr_addr_captured", {22'd0, a_ram_addr}, 32'h012);
    set_m(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    check("wr_back_idle", {31'd0, a_busy}, 32'd0);
    do_single(1'b0, 1'b0, 10'h012, 16'h0);

    // Round-robin: both stream reads, grants alternate starting with master 0
    do_single(1'b0, 1'b1, 10'h020, 16'h1A1A);
    do_single(1'b1, 1'b1, 10'h021, 16'h2B2B);
    push(1'b0, 1'b0, 10'h020, 16'h0);
    push(1'b1, 1'b0, 10'h021, 16'h0);
    push(1'b0, 1'b0, 10'h020, 16'h0);
    push(1'b1, 1'b0, 10'h021, 16'h0);
    set_m(1'b0, 1'b1, 1'b0, 1'b0, 10'h020, 16'h0);
    set_m(1'b1, 1'b1, 1'b0, 1'b0, 10'h021, 16'h0);
    for (int t = 1; t <= 8; t++) begin
      tick();
      check("rr_ack_slot", {31'd0, s_m0_ack | s_m1_ack}, {31'd0, (t % 2) == 0});
    end
    set_m(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_m(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    check("rr_idle", {31'd0, a_busy}, 32'd0);
    check("rr_sb_empty", sb_q.size(), 0);

    // Fixed priority: master 0 starves master 1 until it drops its request
    mon_fp = 1'b1;
    apply_reset();
    repeat (3) push(1'b0, 1'b1, 10'h030, 16'h3030);
    push(1'b1, 1'b1, 10'h031, 16'h3131);
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 10'h030, 16'h3030);
    set_m(1'b1, 1'b1, 1'b1, 1'b0, 10'h031, 16'h3131);
    n    = 0;
    acks = 0;
    while (acks < 4 && n < 30) begin
      tick();
      n++;
      if (s_m0_ack || s_m1_ack) begin
        acks++;
        if (acks == 3) set_m(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        if (acks == 4) set_m(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      end
    end
    check("fp_cycles", n, 8);
    check("fp_sb_empty", sb_q.size(), 0);
    mon_fp = 1'b0;
    apply_reset();

    // Lock: master 1 keeps the bus for initial grant + 4 locked, then master 0
    do_single(1'b0, 1'b1, 10'h040, 16'h4000);
    repeat (5) push(1'b1, 1'b1, 10'h041, 16'h1111);
    push(1'b0, 1'b1, 10'h040, 16'h4444);
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 10'h040, 16'h4444);
    set_m(1'b1, 1'b1, 1'b1, 1'b1, 10'h041, 16'h1111);
    n    = 0;
    acks = 0;
    while (acks < 6 && n < 40) begin
      tick();
      n++;
      if (s_m0_ack || s_m1_ack) acks++;
    end
    set_m(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_m(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    check("lock_cycles", n, 12);
    check("lock_sb_empty", sb_q.size(), 0);
    tick();
    do_single(1'b1, 1'b0, 10'h041, 16'h0);
    do_single(1'b0, 1'b0, 10'h040, 16'h0);

    // Back-to-back: request held through ack starts the next access immediately
    push(1'b0, 1'b1, 10'h050, 16'h1234);
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 10'h050, 16'h1234);
    tick();
    tick();
    check("b2b_first_ack", {31'd0, a_m0_ack}, 32'd1);
    push(1'b0, 1'b1, 10'h100, 16'hCAFE);
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 10'h100, 16'hCAFE);
    tick();
    check("b2b_ram_en", {31'd0, a_ram_en}, 32'd1);
    check("b2b_ram_addr", {22'd0, a_ram_addr}, 32'h100);
    tick();
    check("b2b_second_ack", {31'd0, a_m0_ack}, 32'd1);
    set_m(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    do_single(1'b0, 1'b0, 10'h100, 16'h0);
    do_single(1'b0, 1'b0, 10'h050, 16'h0);

    // Reset during ACCESS drops the transaction; the held request is then serviced
    set_m(1'b1, 1'b1, 1'b1, 1'b0, 10'h060, 16'h7777);
    tick();
    check("mid_ram_en", {31'd0, a_ram_en}, 32'd1);
    check("mid_owner", {31'd0, a_owner}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ram_en", {31'd0, a_ram_en}, 32'd0);
    check("mid_rst_owner", {31'd0, a_owner}, 32'd0);
    check("mid_rst_busy", {31'd0, a_busy}, 32'd0);
    tick();
    check("mid_rst_acks", {30'd0, a_m1_ack, a_m0_ack}, 32'd0);
    push(1'b1, 1'b1, 10'h060, 16'h8888);
    set_m(1'b1, 1'b1, 1'b1, 1'b0, 10'h060, 16'h8888);
    rst_n = 1'b1;
    n = 0;
    while (!s_m1_ack && n < 8) begin
      tick();
      n++;
    end
    check("post_rst_latency", n, 2);
    set_m(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    do_single(1'b1, 1'b0, 10'h060, 16'h0);
    check("final_sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
